// File: rtl/reg_file_pipe_if.sv
// Decode/writeback-facing bundle of the pipelined register file.
// master = issue/writeback side, slave = register file.
interface reg_file_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] RSaddr;
    logic [ADDR_W-1:0] RTaddr;
    logic [DATA_W-1:0] srcl;
    logic [DATA_W-1:0] RTdata;
    logic              rd_valid;
    logic              RegWrite;
    logic [ADDR_W-1:0] RDaddr;
    logic [DATA_W-1:0] RDdata;
    logic              reserve_en;
    logic [ADDR_W-1:0] reserve_addr;
    logic              rs_pending;
    logic              rt_pending;
    logic              init_busy;

    modport master (
        output rd_en, RSaddr, RTaddr, RegWrite, RDaddr, RDdata, reserve_en, reserve_addr,
        input  srcl, RTdata, rd_valid, rs_pending, rt_pending, init_busy
    );

    modport slave (
        input  rd_en, RSaddr, RTaddr, RegWrite, RDaddr, RDdata, reserve_en, reserve_addr,
        output srcl, RTdata, rd_valid, rs_pending, rt_pending, init_busy
    );
endinterface

// File: rtl/reg_file_pipe.sv
// Pipelined 2R/1W register file with reset zero-sweep and pending scoreboard.
// Optional macro RF_BYPASS_EN: write-first on same-edge read/write collision.
module reg_file_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_pipe_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] r_srcl;
    logic [DATA_W-1:0] r_rtdata;
    logic              r_rd_valid;
    logic              r_init_busy;

    logic              w_run;
    logic              w_wr_ok;
    logic              w_res_ok;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    function automatic logic [DATA_W-1:0] f_rd(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] stored,
                                               input logic              hit,
                                               input logic [DATA_W-1:0] wdata);
        if (ZERO_REG != 0 && a == '0) return '0;
        if (hit) return wdata;
        return stored;
    endfunction

    assign w_run    = (r_state == S_RUN);
    assign w_wr_ok  = w_run && bus.RegWrite && !(ZERO_REG != 0 && bus.RDaddr == '0);
    assign w_res_ok = bus.reserve_en && !(ZERO_REG != 0 && bus.reserve_addr == '0);

`ifdef RF_BYPASS_EN
    assign w_rs_hit = w_wr_ok && (bus.RSaddr == bus.RDaddr);
    assign w_rt_hit = w_wr_ok && (bus.RTaddr == bus.RDaddr);
`else
    // Read-first: the array read below already sees pre-write contents.
    assign w_rs_hit = 1'b0;
    assign w_rt_hit = 1'b0;
`endif

    assign w_rs_data = f_rd(bus.RSaddr, r_mem[bus.RSaddr], w_rs_hit, bus.RDdata);
    assign w_rt_data = f_rd(bus.RTaddr, r_mem[bus.RTaddr], w_rt_hit, bus.RDdata);

    // The sweep and the writeback port share the single array write port.
    assign w_mem_we   = !rst && (!w_run || w_wr_ok);
    assign w_mem_addr = w_run ? bus.RDaddr : r_cnt;
    assign w_mem_data = w_run ? bus.RDdata : '0;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_srcl      <= '0;
            r_rtdata    <= '0;
            r_rd_valid  <= 1'b0;
            r_init_busy <= 1'b1;
            r_pend      <= '0;
        end else if (r_state == S_INIT) begin
            r_rd_valid <= 1'b0;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_state     <= S_RUN;
                r_init_busy <= 1'b0;
            end
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_srcl   <= w_rs_data;
                r_rtdata <= w_rt_data;
            end
            // Set after clear so a same-edge reservation of RDaddr wins.
            if (bus.RegWrite) r_pend[bus.RDaddr] <= 1'b0;
            if (w_res_ok) r_pend[bus.reserve_addr] <= 1'b1;
        end
    end

    assign bus.srcl       = r_srcl;
    assign bus.RTdata     = r_rtdata;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.init_busy  = r_init_busy;
    assign bus.rs_pending = w_run & r_pend[bus.RSaddr];
    assign bus.rt_pending = w_run & r_pend[bus.RTaddr];
endmodule

// File: tb/tb_reg_file_pipe.sv
// Self-checking bench for reg_file_pipe: read expectations are queued at issue
// and popped by a monitor when rd_valid fires.
module tb_reg_file_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] t;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    rd_exp_t     mon_e;
    logic [31:0] mem_m [DEPTH];
    logic [DEPTH-1:0] pend_m;
    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (we && a == wa) return wd;
`endif
        return mem_m[a];
    endfunction

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected: rd_valid=1 required=0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                popped++;
                if (bus.srcl !== mon_e.s || bus.RTdata !== mon_e.t) begin
                    errors++;
                    $display("FAIL read_data: srcl=%h RTdata=%h required %h %h at %0t",
                             bus.srcl, bus.RTdata, mon_e.s, mon_e.t, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic res, input logic [4:0] ra, input logic model_on);
        bus.rd_en        = rd;
        bus.RSaddr       = rs;
        bus.RTaddr       = rt;
        bus.RegWrite     = we;
        bus.RDaddr       = wa;
        bus.RDdata       = wd;
        bus.reserve_en   = res;
        bus.reserve_addr = ra;
        if (model_on) begin
            if (rd) begin
                exp_q.push_back('{s: exp_rd(rs, we, wa, wd), t: exp_rd(rt, we, wa, wd)});
                pushed++;
            end
            if (we && wa != 5'd0) mem_m[wa] = wd;
            if (we) pend_m[wa] = 1'b0;
            if (res && ra != 5'd0) pend_m[ra] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b0, rs, rt, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
        pend_m = '0;
    endtask

    // Reset with traffic on every input during the sweep; all of it must be ignored.
    task automatic sweep_after_reset(input string tag);
        int n;
        n = 0;
        rst = 1'b1;
        idle(5'd0, 5'd0);
        tick();
        rst = 1'b0;
        while (bus.init_busy === 1'b1 && n < 200) begin
            drive(1'b1, 5'(n), 5'd6, 1'b1, 5'd4, 32'h55, 1'b1, 5'd6, 1'b0);
            #1;
            checks++;
            if (bus.rs_pending !== 1'b0 || bus.rt_pending !== 1'b0) begin
                errors++;
                $display("FAIL %s_pending_in_init: rs=%b rt=%b required 0 0", tag,
                         bus.rs_pending, bus.rt_pending);
            end
            n++;
            tick();
        end
        idle(5'd0, 5'd0);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL %s_init_busy_len: cycles=%0d required=%0d", tag, n, DEPTH);
        end
        model_clear();
    endtask

    task automatic test_reset();
        sweep_after_reset("reset");
        checks++;
        if (bus.srcl !== 32'd0 || bus.RTdata !== 32'd0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: srcl=%h RTdata=%h rd_valid=%b required 0 0 0",
                     bus.srcl, bus.RTdata, bus.rd_valid);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 5'(a), 5'(DEPTH-1-a), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
            #1;
            checks++;
            if (bus.rs_pending !== pend_m[a]) begin
                errors++;
                $display("FAIL reset_pending_r%0d: got=%b required=%b", a, bus.rs_pending, pend_m[a]);
            end
            tick();
        end
        idle(5'd0, 5'd0);
        tick();
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hEA, 1'b0, 5'd0, 1'b1);
        tick();
        drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        tick();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.srcl !== 32'hEA || bus.RTdata !== 32'hEA) begin
            errors++;
            $display("FAIL write_read: rd_valid=%b srcl=%h RTdata=%h required 1 ea ea",
                     bus.rd_valid, bus.srcl, bus.RTdata);
        end
        idle(5'd0, 5'd0);
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.srcl !== 32'hEA) begin
            errors++;
            $display("FAIL read_hold: rd_valid=%b srcl=%h required 0 ea", bus.rd_valid, bus.srcl);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1);
        tick();
        idle(5'd0, 5'd0);
        #1;
        checks++;
        if (bus.rs_pending !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_pending: got=%b required=0", bus.rs_pending);
        end
        tick();
        tick();
    endtask

    task automatic test_collision();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h7F, 1'b0, 5'd0, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h3E8, 1'b0, 5'd0, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        tick();
        idle(5'd0, 5'd0);
        tick();
        tick();
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1);
        tick();
        idle(5'd9, 5'd9);
        #1;
        checks++;
        if (bus.rs_pending !== 1'b1 || bus.rt_pending !== 1'b1) begin
            errors++;
            $display("FAIL sb_reserve: rs=%b rt=%b required 1 1", bus.rs_pending, bus.rt_pending);
        end
        drive(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1);
        tick();
        checks++;
        if (bus.rs_pending !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear: got=%b required=0", bus.rs_pending);
        end
        drive(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h9A, 1'b1, 5'd9, 1'b1);
        tick();
        checks++;
        if (bus.rs_pending !== 1'b1) begin
            errors++;
            $display("FAIL sb_same_edge: got=%b required=1", bus.rs_pending);
        end
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h9B, 1'b0, 5'd0, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] rs, rt, wa, ra;
        logic       exp_rs, exp_rt;
        for (int i = 0; i < 80; i++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            exp_rs = pend_m[rs];
            exp_rt = pend_m[rt];
            drive(1'($urandom_range(0, 1)), rs, rt, 1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), ra, 1'b1);
            #1;
            checks++;
            if (bus.rs_pending !== exp_rs || bus.rt_pending !== exp_rt) begin
                errors++;
                $display("FAIL b2b_pending_%0d: rs=%b rt=%b required %b %b", i,
                         bus.rs_pending, bus.rt_pending, exp_rs, exp_rt);
            end
            tick();
        end
        idle(5'd0, 5'd0);
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hB7, 1'b1, 5'd12, 1'b1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h14, 1'b1, 5'd3, 1'b1);
        tick();
        rst = 1'b1;
        idle(5'd0, 5'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.init_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: got=%b required=1", bus.init_busy);
        end
        sweep_after_reset("mid_reset");
        for (int a = 0; a < DEPTH; a++) begin
            idle(5'(a), 5'(a));
            #1;
            checks++;
            if (bus.rs_pending !== 1'b0 || bus.rt_pending !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_pending_r%0d: rs=%b rt=%b required 0 0", a,
                         bus.rs_pending, bus.rt_pending);
            end
        end
        drive(1'b1, 5'd3, 5'd20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        tick();
        drive(1'b1, 5'd12, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        tick();
        idle(5'd0, 5'd0);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        idle(5'd0, 5'd0);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0 || pushed != popped) begin
            errors++;
            $display("FAIL read_drain: pending=%0d popped=%0d required pushed=%0d",
                     exp_q.size(), popped, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_pipe.md
Name: reg_file_pipe

Overview:
Parametrised, pipelined successor to the core's general-purpose register file. It provides two read ports with a 1-cycle registered read and one write port, and zeroes itself after reset with a sequential sweep. It also keeps a per-register pending scoreboard so the issue stage can detect in-flight producers. It sits between decode (read addresses, reservations) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
rd_en  in  1  read request; RSaddr/RTaddr are sampled when high
RSaddr  in  ADDR_W  source-S read address
RTaddr  in  ADDR_W  source-T read address
srcl  out  DATA_W  registered read data, S port
RTdata  out  DATA_W  registered read data, T port
rd_valid  out  1  one-cycle pulse: srcl/RTdata carry new data
RegWrite  in  1  write enable
RDaddr  in  ADDR_W  write address
RDdata  in  DATA_W  write data
reserve_en  in  1  mark reserve_addr as pending
reserve_addr  in  ADDR_W  register being reserved
rs_pending  out  1  combinational: pending bit of RSaddr
rt_pending  out  1  combinational: pending bit of RTaddr
init_busy  out  1  high while the reset sweep runs

Behaviour:
- Reset: rst is synchronous and active-high, sampled on the clk rising edge. At the edge where rst=1:
  - state <= INIT, sweep counter <= 0.
  - srcl=0, RTdata=0, rd_valid=0, init_busy=1.
  - All pending bits cleared.
- Reset mid-sweep or mid-operation restarts the sweep from address 0.
- INIT state:
  - Each cycle writes 0 to register[counter], then counter+1.
  - After the write to DEPTH-1, state <= RUN and init_busy <= 0.
  - init_busy is high for exactly DEPTH cycles after the last rst=1 edge.
  - rd_en, RegWrite and reserve_en are ignored; rd_valid stays 0; rs_pending and rt_pending read 0.
- RUN state, read:
  - rd_en=1 at edge N: srcl/RTdata load register[RSaddr]/register[RTaddr]; rd_valid=1 for the cycle after edge N.
  - rd_en=0: srcl/RTdata hold their last values; rd_valid=0.
- RUN state, write:
  - RegWrite=1 at an edge: register[RDaddr] <= RDdata.
  - If ZERO_REG=1 and RDaddr=0, the write is dropped.
- Zero register: if ZERO_REG=1, a read of address 0 returns 0 regardless of contents.
- Read/write collision (same edge, read address == RDaddr): the returned value depends on RF_BYPASS_EN (see Optional Feature).
- Both read ports may use the same address; both return the identical value.
- Scoreboard:
  - reserve_en=1 sets pending[reserve_addr].
  - RegWrite=1 clears pending[RDaddr].
  - Same edge, reserve_addr == RDaddr: the bit ends set (the new producer wins).
  - If ZERO_REG=1, reserving address 0 is ignored.
  - rs_pending = pending[RSaddr] and rt_pending = pending[RTaddr], combinational from the current addresses and stored bits.
  - A write does not require a prior reservation; clearing an already-clear bit is harmless.
- Width rules: addresses are exactly ADDR_W bits, so there is no out-of-range case. Data is stored unmodified at DATA_W bits.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: on a same-edge collision, the read port returns RDdata (write-first). The ZERO_REG rule still forces address 0 to return 0.
- Undefined: on a same-edge collision, the read port returns the pre-write contents (read-first); the new value is visible from the next read.
- The scoreboard and INIT behaviour are identical either way.

Test Plan:
1. Reset sweep: hold rst=1 for 1 cycle with DEPTH=32 -> init_busy=1 for exactly 32 cycles; then read every address -> 0; no rd_valid during INIT.
2. Write then read: write R5=0x000000EA; next cycle rd_en with RSaddr=5, RTaddr=5 -> after 1 cycle srcl=RTdata=0xEA, rd_valid=1 for one cycle.
3. Zero register: write R0=0xFFFFFFFF, then read R0 -> 0; reserve R0 -> rs_pending=0.
4. Collision: R7=0x7F; same edge write R7=0x3E8 and read R7 -> srcl=0x3E8 with RF_BYPASS_EN, 0x7F without; the next read returns 0x3E8 in both builds.
5. Scoreboard: reserve R9 -> rs_pending=1 with RSaddr=9; write R9 -> 0. Same-edge reserve R9 and write R9 -> pending stays 1.
6. Mid-operation reset: write R3=0xB7, assert rst during the sweep at counter=10 -> sweep restarts; R3 reads 0 and all pending bits read 0.
